game_timer: RTL

GAME_TIMER -- requirements
Module: game_timer

---
 rtl/game_timer.sv | 80 ++++++++
 1 files changed

// File: rtl/game_timer.sv
// game_timer: countdown game timer with pause, bonus time, low-time warning and BCD display
module game_timer #(
    parameter int INIT_SEC  = 60,
    parameter int BONUS_SEC = 5,
    parameter int MAX_SEC   = 99,
    parameter int WARN_SEC  = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       pause,
    input  logic       one_second_enable,
    input  logic       bonus,
    output logic       running,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       warning,
    output logic       time_up,
    output logic       game_over
);
    typedef enum logic [1:0] {IDLE, RUN, PAUSED, OVER} state_t;
    state_t state, state_n;
    logic [6:0] count, count_n;
    logic       tick_d, tick, time_up_n;
    logic [7:0] sum;
    // A tick is a fresh rising edge; tick_d resets high so a level held through reset is ignored.
    assign tick = one_second_enable & ~tick_d;
    // Bonus arithmetic folds in a same-cycle tick so the result can never expire the game.
    assign sum = {1'b0, count} + 8'(BONUS_SEC) - {7'd0, tick};
    assign running = (state == RUN) || (state == PAUSED);
    assign game_over = state == OVER;
    assign warning = running && count != 7'd0 && count <= 7'(WARN_SEC);
    assign sec_tens = 4'(count / 7'd10);
    assign sec_ones = 4'(count % 7'd10);
    // State, count, edge-detect and expiry pulse registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            count   <= 7'(INIT_SEC);
            tick_d  <= 1'b1;
            time_up <= 1'b0;
        end else begin
            state   <= state_n;
            count   <= count_n;
            tick_d  <= one_second_enable;
            time_up <= time_up_n;
        end
    end
    // Next state and count; in RUN, start beats pause, which beats tick/bonus.
    always_comb begin
        state_n   = state;
        count_n   = count;
        time_up_n = 1'b0;
        case (state)
            IDLE: begin
                count_n = 7'(INIT_SEC);
                if (start) state_n = RUN;
            end
            RUN: begin
                if (start) count_n = 7'(INIT_SEC);
                else if (pause) state_n = PAUSED;
                else if (bonus) count_n = sum > 8'(MAX_SEC) ? 7'(MAX_SEC) : sum[6:0];
                else if (tick) begin
                    if (count > 7'd1) count_n = count - 7'd1;
                    else begin
                        count_n   = 7'd0;
                        state_n   = OVER;
                        time_up_n = 1'b1;
                    end
                end
            end
            PAUSED: if (!pause) state_n = RUN;
            OVER: begin
                count_n = start ? 7'(INIT_SEC) : 7'd0;
                if (start) state_n = RUN;
            end
            default: state_n = IDLE;
        endcase
    end
endmodule
